// File: rtl/pdm_pkg.sv
// pdm_pkg: shared state encoding and default parameters for the PDM transmitter
package pdm_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, STOP} pdm_tx_state_t;
  localparam logic [15:0] PDM_SILENCE = 16'h8000;
  localparam int DEF_CLK_DIV = 40;
  localparam int DEF_DECIM = 64;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/pdm_audio_out_if.sv
// pdm_audio_out_if: PCM sample valid/ready handshake into the PDM transmitter
interface pdm_audio_out_if #(
  parameter int SAMPLE_W = pdm_pkg::DEF_SAMPLE_W
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic sample_valid;
  logic sample_ready;
  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two FIFO with extra-bit pointers and synchronous flush
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push;
  assign do_push = push_i && !full_o && !flush_i;
  assign empty_o = wr_q == rd_q;
  assign full_o = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) rd_q <= wr_q;
    else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/pdm_audio_out.sv
// pdm_audio_out: buffered PCM to first-order sigma-delta PDM transmitter with
// its own bit clock and amplifier shutdown control
module pdm_audio_out
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DECIM = DEF_DECIM,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  pdm_audio_out_if.slave s,
  output logic pdmClk,
  output logic pdmData,
  output logic audSd,
  output logic underrun,
  output logic busy
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DECIM);
  localparam logic [SAMPLE_W-1:0] SIL = SAMPLE_W'(1) << (SAMPLE_W - 1);
  pdm_tx_state_t state_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] bit_q;
  logic [SAMPLE_W-1:0] acc_q, cur_q, dout;
  logic [SAMPLE_W:0] sum;
  logic full, empty, run, tick, bound, push, pop, flush;
  assign run = state_q == RUN || state_q == STOP;
  assign tick = run && div_q == DW'(CLK_DIV - 1);
  assign bound = tick && bit_q == BW'(DECIM - 1);
  assign sum = {1'b0, acc_q} + {1'b0, cur_q};
  assign push = s.sample_valid && s.sample_ready;
  assign pop = !empty && ((state_q == START && enable) || (state_q == RUN && bound));
  assign flush = state_q == STOP && bound;
  assign s.sample_ready = !reset && !full && state_q != STOP;
  assign pdmClk = run && div_q < DW'(CLK_DIV / 2);
  assign busy = state_q != IDLE;
  sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .flush_i(flush),
    .data_i(s.sample_in), .data_o(dout), .full_o(full), .empty_o(empty)
  );
  // pdmData takes the carry on the tick, so it changes with the pdmClk rising edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      div_q <= '0;
      bit_q <= '0;
      acc_q <= '0;
      cur_q <= '0;
      pdmData <= 1'b0;
      audSd <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (run) div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        acc_q <= sum[SAMPLE_W-1:0];
        pdmData <= sum[SAMPLE_W];
        bit_q <= bit_q + 1'b1;
      end
      case (state_q)
        IDLE: if (enable) begin
          underrun <= 1'b0;
          state_q <= START;
        end
        START: if (!enable) state_q <= IDLE;
        else if (!empty) begin
          cur_q <= dout ^ SIL;
          acc_q <= '0;
          div_q <= '0;
          bit_q <= '0;
          audSd <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (bound) begin
            cur_q <= empty ? SIL : dout ^ SIL;
            if (empty) underrun <= 1'b1;
          end
          if (!enable) state_q <= STOP;
        end
        default: if (bound) begin
          pdmData <= 1'b0;
          audSd <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_pdm_audio_out.sv
// tb_pdm_audio_out: randomized playback checks against an integer sigma-delta model
module tb_pdm_audio_out;
  import pdm_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic pdm_clk, pdm_data, aud_sd, underrun, busy;
  int checks = 0;
  int errors = 0;
  int acc_m, cnt_m, cur_m;
  logic und_m;
  int q_m[$];
  int period, high;

  pdm_audio_out_if bus ();
  pdm_audio_out dut (
    .clk(clk), .reset(reset), .enable(enable), .s(bus.slave),
    .pdmClk(pdm_clk), .pdmData(pdm_data), .audSd(aud_sd),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: accumulator as an integer mod 2^16, carry = wrap; 64 bits per sample
  task automatic model_start();
    acc_m = 0;
    cnt_m = 0;
    und_m = 1'b0;
    cur_m = (q_m.size() > 0) ? q_m.pop_front() : int'(PDM_SILENCE);
  endtask

  task automatic model_bit(output logic b);
    acc_m += cur_m;
    b = acc_m >= 65536;
    acc_m %= 65536;
    cnt_m++;
    if (cnt_m == 64) begin
      cnt_m = 0;
      if (q_m.size() > 0) cur_m = q_m.pop_front();
      else begin
        cur_m = int'(PDM_SILENCE);
        und_m = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [15:0] x);
    int n = 0;
    bus.sample_in = x;
    bus.sample_valid = 1'b1;
    while (!bus.sample_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL push_timeout ready=%b required 1", bus.sample_ready);
    end
    step();
    bus.sample_valid = 1'b0;
    q_m.push_back(int'($signed(x)) + 32768);
  endtask

  task automatic next_bit(output logic b);
    logic prev;
    int n = 0;
    high = 0;
    do begin
      prev = pdm_clk;
      step();
      n++;
      high += int'(pdm_clk);
    end while (!(prev && !pdm_clk) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL pdmclk_fall_timeout got no fall in %0d clks", n);
    end
    period = n;
    b = pdm_data;
  endtask

  task automatic wait_run();
    logic b;
    int n = 0;
    while (!aud_sd && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (aud_sd !== 1'b1) begin
      errors++;
      $display("FAIL run_start audSd=%b required 1", aud_sd);
    end
    next_bit(b);
    checks++;
    if (b !== 1'b0 || period !== 20) begin
      errors++;
      $display("FAIL first_bit data=%b clks=%0d required 0 and 20", b, period);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
    checks++;
    if ({aud_sd, pdm_data, pdm_clk} !== 3'b000) begin
      errors++;
      $display("FAIL idle_outputs audSd,data,clk=%b required 000", {aud_sd, pdm_data, pdm_clk});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'h7fff;
    repeat (3) step();
    checks++;
    if ({pdm_clk, pdm_data, aud_sd, underrun, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 00000", {pdm_clk, pdm_data, aud_sd, underrun, busy});
    end
    checks++;
    if (bus.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b required 0", bus.sample_ready);
    end
    bus.sample_valid = 1'b0;
    enable = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if (bus.sample_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready ready=%b busy=%b required 1 0", bus.sample_ready, busy);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pats [4] = '{16'h4000, 16'h0000, 16'h8000, 16'h7fff};
    int ones_exp [4] = '{48, 32, 0, 63};
    logic b, e;
    int ones;
    for (int p = 0; p < 4; p++) begin
      push(pats[p]);
      push(pats[p]);
      enable = 1'b1;
      wait_run();
      model_start();
      ones = 0;
      for (int k = 0; k < 64; k++) begin
        next_bit(b);
        model_bit(e);
        ones += int'(b);
        checks++;
        if (b !== e) begin
          errors++;
          $display("FAIL pattern_%h bit %0d got %b required %b", pats[p], k, b, e);
        end
        if (p == 0 && k == 8) begin
          checks++;
          if (period !== 40 || high !== 20 || aud_sd !== 1'b1) begin
            errors++;
            $display("FAIL pdmclk_shape period=%0d high=%0d audSd=%b required 40 20 1", period, high, aud_sd);
          end
        end
      end
      checks++;
      if (ones !== ones_exp[p]) begin
        errors++;
        $display("FAIL density_%h got %0d ones required %0d", pats[p], ones, ones_exp[p]);
      end
      enable = 1'b0;
      wait_idle(3000);
      q_m.delete();
    end
  endtask

  task automatic test_stop_mid();
    logic b, e, seen;
    push(16'($urandom));
    push(16'($urandom));
    enable = 1'b1;
    wait_run();
    model_start();
    for (int k = 0; k < 63; k++) begin
      next_bit(b);
      model_bit(e);
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL stop_bit %0d got %b required %b", k, b, e);
      end
      if (k == 10) enable = 1'b0;
      if (k == 11) begin
        checks++;
        if ({bus.sample_ready, busy, aud_sd} !== 3'b011) begin
          errors++;
          $display("FAIL stop_state ready,busy,audSd=%b required 011", {bus.sample_ready, busy, aud_sd});
        end
      end
    end
    wait_idle(100);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL stop_underrun got %b required 0", underrun);
    end
    q_m.delete();
    enable = 1'b1;
    seen = 1'b0;
    repeat (200) begin
      step();
      seen |= aud_sd;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flushed_fifo audSd_seen=%b busy=%b required 0 1", seen, busy);
    end
    enable = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic b, e;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    checks++;
    if (bus.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b required 0", bus.sample_ready);
    end
    bus.sample_in = 16'h1234;
    bus.sample_valid = 1'b1;
    repeat (5) step();
    bus.sample_valid = 1'b0;
    enable = 1'b1;
    wait_run();
    model_start();
    for (int k = 0; k < 320; k++) begin
      next_bit(b);
      model_bit(e);
      checks++;
      if (b !== e || underrun !== und_m) begin
        errors++;
        $display("FAIL b2b_bit %0d data=%b underrun=%b required %b %b", k, b, underrun, e, und_m);
      end
    end
    enable = 1'b0;
    wait_idle(3000);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b required 1", underrun);
    end
    q_m.delete();
  endtask

  task automatic test_reset_mid();
    logic b, e;
    int n = 0;
    push(16'h4000);
    enable = 1'b1;
    wait_run();
    model_start();
    for (int k = 0; k < 95; k++) begin
      next_bit(b);
      model_bit(e);
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL pre_reset_bit %0d got %b required %b", k, b, e);
      end
    end
    while (!(pdm_data && pdm_clk) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if ({underrun, aud_sd, pdm_data, pdm_clk} !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset und,audSd,data,clk=%b required 1111", {underrun, aud_sd, pdm_data, pdm_clk});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pdm_clk, pdm_data, aud_sd} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset clk,data,audSd=%b required 000", {pdm_clk, pdm_data, aud_sd});
    end
    checks++;
    if ({underrun, busy, bus.sample_ready} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_flags und,busy,ready=%b required 000", {underrun, busy, bus.sample_ready});
    end
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    q_m.delete();
    push(16'h4000);
    enable = 1'b1;
    wait_run();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL reenable_underrun got %b required 0", underrun);
    end
    model_start();
    for (int k = 0; k < 16; k++) begin
      next_bit(b);
      model_bit(e);
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL fresh_bit %0d got %b required %b", k, b, e);
      end
    end
    enable = 1'b0;
    wait_idle(3000);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stop_mid();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
